// File: rtl/voice_pkg.sv
// voice_pkg: shared widths, default key half-periods and the voice state type
// used by the voice scheduler and its tone voices.
package voice_pkg;
   localparam int KEY_W     = 2;
   localparam int DIV_W_DEF = 17;
   localparam int AGE_W_DEF = 4;
   localparam int HP0_DEF   = 113636;
   localparam int HP1_DEF   = 101238;
   localparam int HP2_DEF   = 95556;
   localparam int HP3_DEF   = 85131;
   typedef struct packed {
      logic                 busy;
      logic [KEY_W-1:0]     key;
      logic [AGE_W_DEF-1:0] age;
      logic [DIV_W_DEF-1:0] counter;
      logic                 phase;
   } voice_t;
endpackage

// File: rtl/tone_voice.sv
// tone_voice: one square-wave voice; phase toggles every half_period cycles while run is high.
module tone_voice
   import voice_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             load,
   input  logic [DIV_W-1:0] half_period,
   input  logic             run,
   output logic             phase
);
   localparam logic [DIV_W-1:0] ONE = 1;
   logic [DIV_W-1:0] count;
   always_ff @(posedge CLK) begin
      if (RST || load || !run) begin
         count <= '0;
         phase <= 1'b0;
      end else if (count == half_period - ONE) begin
         count <= '0;
         phase <= ~phase;
      end else begin
         count <= count + ONE;
      end
   end
endmodule

// File: rtl/voice_scheduler.sv
// voice_scheduler: shares NUM_VOICES tone voices among NUM_KEYS key requesters with
// allocation, oldest-voice stealing and release, OR-mixing busy voices into AUDIO.
module voice_scheduler
   import voice_pkg::*;
#(
   parameter int NUM_KEYS   = 4,
   parameter int NUM_VOICES = 2,
   parameter int DIV_W      = DIV_W_DEF,
   parameter int AGE_W      = AGE_W_DEF,
   parameter int HP0        = HP0_DEF,
   parameter int HP1        = HP1_DEF,
   parameter int HP2        = HP2_DEF,
   parameter int HP3        = HP3_DEF
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic [NUM_KEYS-1:0]         KEYS,
   output logic                        AUDIO,
   output logic [NUM_VOICES-1:0]       VOICE_BUSY,
   output logic [NUM_VOICES*KEY_W-1:0] VOICE_KEY,
   output logic                        STEAL
);
   localparam logic [NUM_KEYS-1:0]   KEY_ONE = 1;
   localparam logic [NUM_VOICES-1:0] V_ONE   = 1;
   localparam logic [AGE_W-1:0]      AGE_ONE = 1;
   logic [NUM_KEYS-1:0]   s1, s2, prev, pending, rise, fall, avail, clr;
   logic [NUM_VOICES-1:0] busy, phase, sel, idle_sel, old_sel, rel;
   logic [KEY_W-1:0]      key [NUM_VOICES];
   logic [AGE_W-1:0]      age [NUM_VOICES];
   logic [AGE_W-1:0]      best;
   logic [KEY_W-1:0]      k;
   logic [DIV_W-1:0]      hp [4];
   logic                  req, owned, steal_c;
   assign hp = '{DIV_W'(HP0), DIV_W'(HP1), DIV_W'(HP2), DIV_W'(HP3)};
   assign rise = s2 & ~prev;
   assign fall = ~s2 & prev;
   // A key falling in the same cycle it would be serviced is dropped, never allocated.
   assign avail = pending & ~fall;
   assign req = |avail;
   assign idle_sel = ~busy & (busy + V_ONE);
   always_comb begin
      k = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--)
         if (avail[i]) k = KEY_W'(i);
      owned = 1'b0;
      for (int v = 0; v < NUM_VOICES; v++)
         if (busy[v] && key[v] == k) owned = 1'b1;
      old_sel = V_ONE;
      best = age[0];
      for (int v = 1; v < NUM_VOICES; v++)
         if (age[v] > best) begin
            best = age[v];
            old_sel = V_ONE << v;
         end
      steal_c = req && !owned && &busy;
      sel = (req && !owned) ? (&busy ? old_sel : idle_sel) : '0;
      clr = req ? KEY_ONE << k : '0;
      for (int v = 0; v < NUM_VOICES; v++)
         rel[v] = busy[v] & fall[key[v]];
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         s1 <= '0;
         s2 <= '0;
         prev <= '0;
         pending <= '0;
         busy <= '0;
         STEAL <= 1'b0;
         AUDIO <= 1'b0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            key[v] <= '0;
            age[v] <= '0;
         end
      end else begin
         s1 <= KEYS;
         s2 <= s1;
         prev <= s2;
         pending <= (pending & ~clr | rise) & ~fall;
         STEAL <= steal_c;
         AUDIO <= |(busy & phase);
         for (int v = 0; v < NUM_VOICES; v++)
            if (sel[v]) begin
               busy[v] <= 1'b1;
               key[v] <= k;
               age[v] <= '0;
            end else if (rel[v]) begin
               busy[v] <= 1'b0;
               key[v] <= '0;
            end else if (|sel && busy[v] && age[v] != '1) begin
               age[v] <= age[v] + AGE_ONE;
            end
      end
   end
   assign VOICE_BUSY = busy;
   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
      assign VOICE_KEY[g*KEY_W +: KEY_W] = key[g];
      tone_voice #(.DIV_W(DIV_W)) u_voice (
         .CLK        (CLK),
         .RST        (RST),
         .load       (sel[g] | rel[g]),
         .half_period(hp[key[g]]),
         .run        (busy[g]),
         .phase      (phase[g])
      );
   end
endmodule

// File: tb/tb_voice_scheduler.sv
// tb_voice_scheduler: directed and random key stimulus; a time-based reference model
// pushes expected outputs per edge and a monitor pops and compares them.
module tb_voice_scheduler;
   import voice_pkg::*;
   typedef struct packed {
      logic       audio;
      logic [1:0] busy;
      logic [3:0] vkey;
      logic       steal;
   } exp_t;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] keys = 4'b1111;
   logic       audio, steal;
   logic [1:0] vbusy;
   logic [3:0] vkey;
   int         errors = 0, checks = 0;
   exp_t       q[$];
   voice_scheduler #(.HP0(4), .HP1(5), .HP2(6), .HP3(7)) dut (
      .CLK(clk), .RST(rst), .KEYS(keys), .AUDIO(audio),
      .VOICE_BUSY(vbusy), .VOICE_KEY(vkey), .STEAL(steal)
   );
   always #5 clk = ~clk;
   // Reference model: phase from elapsed time since allocation, age from allocation order.
   int         hp[4] = '{4, 5, 6, 7};
   voice_t     mv[2];
   int         ta[2], seq[2];
   int         t = 0, nalloc = 0;
   logic [3:0] h0 = '0, h1 = '0, h2 = '0, pend = '0;
   logic       mix = 1'b0;
   always @(posedge clk) begin
      exp_t e;
      logic [3:0] rise, fall, avail;
      int sel, kk, a, ba;
      bit own, stl;
      t++;
      e = '0;
      if (rst) begin
         h0 = '0; h1 = '0; h2 = '0; pend = '0; mix = 1'b0;
         for (int v = 0; v < 2; v++) mv[v] = '0;
      end else begin
         rise = h1 & ~h2;
         fall = ~h1 & h2;
         avail = pend & ~fall;
         sel = -1;
         stl = 0;
         if (avail != 0) begin
            kk = 0;
            while (!avail[kk]) kk++;
            pend[kk] = 1'b0;
            own = 0;
            for (int v = 0; v < 2; v++) if (mv[v].busy && mv[v].key == kk) own = 1;
            if (!own) begin
               for (int v = 1; v >= 0; v--) if (!mv[v].busy) sel = v;
               if (sel < 0) begin
                  stl = 1;
                  ba = -1;
                  for (int v = 0; v < 2; v++) begin
                     a = nalloc - seq[v];
                     if (a > 15) a = 15;
                     if (a > ba) begin ba = a; sel = v; end
                  end
               end
               nalloc++;
               seq[sel] = nalloc;
               ta[sel] = t;
               mv[sel].busy = 1'b1;
               mv[sel].key = kk[1:0];
            end
         end
         for (int v = 0; v < 2; v++)
            if (v != sel && mv[v].busy && fall[mv[v].key]) begin
               mv[v].busy = 1'b0;
               mv[v].key = '0;
            end
         pend = (pend | rise) & ~fall;
         e.audio = mix;
         e.steal = stl;
         mix = 1'b0;
         for (int v = 0; v < 2; v++) begin
            mv[v].phase = mv[v].busy && (((t - ta[v]) / hp[mv[v].key]) % 2 == 1);
            mix |= mv[v].phase;
         end
         h2 = h1; h1 = h0; h0 = keys;
      end
      for (int v = 0; v < 2; v++) begin
         e.busy[v] = mv[v].busy;
         e.vkey[v*2 +: 2] = mv[v].key;
      end
      q.push_back(e);
   end
   always @(posedge clk) begin
      exp_t e;
      #1;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty at t=%0t", $time);
      end else begin
         e = q.pop_front();
         checks += 3;
         if (audio !== e.audio) begin errors++; $display("FAIL audio t=%0t got %b exp %b", $time, audio, e.audio); end
         if (vbusy !== e.busy) begin errors++; $display("FAIL voice_busy t=%0t got %b exp %b", $time, vbusy, e.busy); end
         if (vkey !== e.vkey) begin errors++; $display("FAIL voice_key t=%0t got %h exp %h", $time, vkey, e.vkey); end
         if (steal !== e.steal) begin errors++; $display("FAIL steal t=%0t got %b exp %b", $time, steal, e.steal); end
      end
   end
   task automatic drive(input logic r, input logic [3:0] k, input int n);
      rst = r;
      keys = k;
      repeat (n) @(negedge clk);
   endtask
   initial begin
      @(negedge clk);
      drive(1, 4'b1111, 3);
      drive(0, 4'b1111, 20);
      drive(0, 4'b0000, 10);
      drive(0, 4'b0001, 30);
      drive(0, 4'b0000, 6);
      drive(0, 4'b0100, 15);
      drive(0, 4'b0000, 6);
      drive(0, 4'b1000, 15);
      drive(0, 4'b0000, 6);
      drive(0, 4'b0001, 2);
      drive(0, 4'b0011, 2);
      drive(0, 4'b0111, 30);
      drive(0, 4'b0000, 6);
      drive(0, 4'b1100, 20);
      drive(0, 4'b0000, 6);
      drive(0, 4'b0010, 1);
      drive(0, 4'b0000, 8);
      drive(0, 4'b0011, 15);
      drive(1, 4'b0011, 1);
      drive(0, 4'b0000, 6);
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 19) == 0)
            drive(1, 4'($urandom_range(0, 15)), $urandom_range(1, 2));
         drive(0, 4'($urandom_range(0, 15)), $urandom_range(1, 25));
      end
      drive(0, 4'b0000, 8);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
